// File: rtl/mem_ctrl_if.sv
// Bundle of the byte-wide RAM/IO bus plus the load/store-buffer and fetch request channels.
// The slave side is the memory controller; the master side is the requesters and RAM.
interface mem_ctrl_if;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;

    logic        lsb_signal;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [31:0] lsb_rdata;
    logic        lsb_done;

    logic        if_signal;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;

    modport slave (
        input  ram_din, io_buffer_full,
        input  lsb_signal, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        input  if_signal, if_addr,
        output ram_dout, ram_a, ram_wr,
        output lsb_rdata, lsb_done, if_data, if_done
    );

    modport master (
        output ram_din, io_buffer_full,
        output lsb_signal, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        output if_signal, if_addr,
        input  ram_dout, ram_a, ram_wr,
        input  lsb_rdata, lsb_done, if_data, if_done
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates LSB and fetch requests onto a byte-wide RAM/IO bus, serialising multi-byte
// little-endian accesses and returning assembled words with a one-cycle done pulse.
module mem_ctrl #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       clear_signal,
    mem_ctrl_if.slave  bus,
    output logic [1:0] dbg_state
);
    // Handshake: a requester raises its signal and holds it (with stable payload) until the
    // matching done pulse; it drops the signal on the edge that ends the done cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_n;
    logic        src_lsb_q, src_lsb_n;
    logic [31:0] addr_q, addr_n, wdata_q, wdata_n, rbuf_q, rbuf_n;
    logic [2:0]  len_q, len_n, a_cnt_q, a_cnt_n, r_cnt_q, r_cnt_n, w_cnt_q, w_cnt_n;
    logic        addr_vld_q, addr_vld_n, din_vld_q, din_vld_n, resume_q, resume_n;
    logic [31:0] ram_a_q, ram_a_n, lsb_rdata_q, lsb_rdata_n, if_data_q, if_data_n;
    logic [7:0]  ram_dout_q, ram_dout_n;
    logic        ram_wr_q, ram_wr_n, lsb_done_q, lsb_done_n, if_done_q, if_done_n;

    logic [31:0] acc_addr, base_addr, base_wdata, rbuf_tmp;
    logic [2:0]  acc_len, w_idx, issue_idx, r_next;
    logic        w_step, cap, is_io;

    always_comb begin
        acc_addr = bus.lsb_signal ? bus.lsb_addr : bus.if_addr;
        case (bus.lsb_len)
            2'b00:   acc_len = 3'd1;
            2'b01:   acc_len = 3'd2;
            default: acc_len = 3'd4;
        endcase
        if (!bus.lsb_signal) acc_len = 3'd4;
        base_addr  = (state_q == IDLE) ? acc_addr : addr_q;
        base_wdata = (state_q == IDLE) ? bus.lsb_wdata : wdata_q;
        is_io      = (base_addr[17:16] == IO_ADDR_HI);
    end

    always_comb begin
        state_n = state_q;     src_lsb_n = src_lsb_q;   addr_n = addr_q;
        wdata_n = wdata_q;     rbuf_n = rbuf_q;         len_n = len_q;
        a_cnt_n = a_cnt_q;     r_cnt_n = r_cnt_q;       w_cnt_n = w_cnt_q;
        addr_vld_n = addr_vld_q; din_vld_n = din_vld_q; resume_n = resume_q;
        ram_a_n = '0;          ram_dout_n = ram_dout_q; ram_wr_n = 1'b0;
        lsb_done_n = 1'b0;     if_done_n = 1'b0;
        lsb_rdata_n = lsb_rdata_q; if_data_n = if_data_q;
        w_step = 1'b0;         w_idx = '0;
        cap = 1'b0;            rbuf_tmp = rbuf_q;
        issue_idx = a_cnt_q;   r_next = r_cnt_q;

        if (!rdy_in) begin
            // Frozen; bytes returning during the pause are lost, so READ reissues on resume.
            ram_a_n    = ram_a_q;
            lsb_done_n = lsb_done_q;
            if_done_n  = if_done_q;
            if (state_q == READ) resume_n = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!clear_signal && (bus.lsb_signal || bus.if_signal)) begin
                        src_lsb_n = bus.lsb_signal;
                        addr_n    = acc_addr;
                        len_n     = acc_len;
                        wdata_n   = bus.lsb_wdata;
                        rbuf_n    = '0;
                        r_cnt_n   = '0;
                        w_cnt_n   = '0;
                        resume_n  = 1'b0;
                        if (bus.lsb_signal && bus.lsb_wr) begin
                            state_n = WRITE;
                            w_step  = 1'b1;
                        end else begin
                            state_n    = READ;
                            ram_a_n    = acc_addr;
                            a_cnt_n    = 3'd1;
                            addr_vld_n = 1'b1;
                            din_vld_n  = 1'b0;
                        end
                    end
                end
                READ: begin
                    if (clear_signal) begin
                        state_n    = IDLE;
                        addr_vld_n = 1'b0;
                        din_vld_n  = 1'b0;
                        resume_n   = 1'b0;
                    end else begin
                        cap = din_vld_q && !resume_q;
                        if (cap) rbuf_tmp[{r_cnt_q[1:0], 3'b000} +: 8] = bus.ram_din;
                        rbuf_n    = rbuf_tmp;
                        r_next    = r_cnt_q + {2'b00, cap};
                        r_cnt_n   = r_next;
                        issue_idx = resume_q ? r_cnt_q : a_cnt_q;
                        resume_n  = 1'b0;
                        if (cap && r_next == len_q) begin
                            state_n    = DONE;
                            addr_vld_n = 1'b0;
                            din_vld_n  = 1'b0;
                            if (src_lsb_q) begin
                                lsb_rdata_n = rbuf_tmp;
                                lsb_done_n  = 1'b1;
                            end else begin
                                if_data_n = rbuf_tmp;
                                if_done_n = 1'b1;
                            end
                        end else begin
                            din_vld_n = resume_q ? 1'b0 : addr_vld_q;
                            if (issue_idx < len_q) begin
                                ram_a_n    = addr_q + {29'd0, issue_idx};
                                a_cnt_n    = issue_idx + 3'd1;
                                addr_vld_n = 1'b1;
                            end else begin
                                addr_vld_n = 1'b0;
                            end
                        end
                    end
                end
                WRITE: begin
                    // Stores are never cancelled by a flush.
                    if (w_cnt_q == len_q) begin
                        state_n    = DONE;
                        lsb_done_n = 1'b1;
                    end else begin
                        w_step = 1'b1;
                        w_idx  = w_cnt_q;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (w_step) begin
                ram_a_n = base_addr + {29'd0, w_idx};
                if (!(is_io && bus.io_buffer_full)) begin
                    ram_wr_n = 1'b1;
                    w_cnt_n  = w_idx + 3'd1;
                    case (w_idx[1:0])
                        2'd0:    ram_dout_n = base_wdata[7:0];
                        2'd1:    ram_dout_n = base_wdata[15:8];
                        2'd2:    ram_dout_n = base_wdata[23:16];
                        default: ram_dout_n = base_wdata[31:24];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;    src_lsb_q <= 1'b0;  addr_q <= '0;     wdata_q <= '0;
            rbuf_q <= '0;       len_q <= '0;        a_cnt_q <= '0;    r_cnt_q <= '0;
            w_cnt_q <= '0;      addr_vld_q <= 1'b0; din_vld_q <= 1'b0; resume_q <= 1'b0;
            ram_a_q <= '0;      ram_dout_q <= '0;   ram_wr_q <= 1'b0;
            lsb_done_q <= 1'b0; if_done_q <= 1'b0;  lsb_rdata_q <= '0; if_data_q <= '0;
        end else begin
            state_q <= state_n;       src_lsb_q <= src_lsb_n;   addr_q <= addr_n;
            wdata_q <= wdata_n;       rbuf_q <= rbuf_n;         len_q <= len_n;
            a_cnt_q <= a_cnt_n;       r_cnt_q <= r_cnt_n;       w_cnt_q <= w_cnt_n;
            addr_vld_q <= addr_vld_n; din_vld_q <= din_vld_n;   resume_q <= resume_n;
            ram_a_q <= ram_a_n;       ram_dout_q <= ram_dout_n; ram_wr_q <= ram_wr_n;
            lsb_done_q <= lsb_done_n; if_done_q <= if_done_n;
            lsb_rdata_q <= lsb_rdata_n; if_data_q <= if_data_n;
        end
    end

    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_data   = if_data_q;
    assign dbg_state     = state_q;
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly downstream of the load/store buffer and the instruction fetch unit.
- Arbitrates their requests onto the single byte-wide RAM/IO bus.
- Serialises 1/2/4-byte little-endian loads, stores and 4-byte instruction fetches into per-byte RAM cycles.
- Returns assembled words with a one-cycle done pulse to the requester.

Parameters:
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks a memory-mapped IO access.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high
- rdy_in  input  1  pause when low
- clear_signal  input  1  misprediction flush
- ram_din  input  8  byte returned by RAM/IO
- ram_dout  output  8  byte to write
- ram_a  output  32  byte address
- ram_wr  output  1  1 = write
- io_buffer_full  input  1  IO write buffer full
- lsb_signal  input  1  LSB request, held until lsb_done
- lsb_wr  input  1  1 = store
- lsb_len  input  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes, 10 = treated as 4
- lsb_addr  input  32  data address
- lsb_wdata  input  32  store data
- lsb_rdata  output  32  load data, zero-extended
- lsb_done  output  1  one-cycle completion pulse
- if_signal  input  1  fetch request, held until if_done
- if_addr  input  32  fetch address, word-aligned
- if_data  output  32  fetched instruction
- if_done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State IDLE.
  - ram_a = 0, ram_dout = 0, ram_wr = 0.
  - lsb_done = 0, if_done = 0, lsb_rdata = 0, if_data = 0.
  - Byte counters = 0. Any operation in flight is dropped.
- States: IDLE, READ, WRITE, DONE.
- Outputs are registered. Outside an active bus cycle: ram_a = 0, ram_wr = 0.
- IDLE (cycle c0):
  - lsb_signal has priority over if_signal.
  - Latch source, addr, N bytes and wdata.
  - Go to READ (load or fetch) or WRITE (store).
- READ:
  - Byte k (k = 0..N-1) is driven as ram_a = addr+k in cycle c0+1+k.
  - Byte k returns on ram_din one cycle later and is captured into bits [8k+7:8k].
  - After byte N-1 is captured, go to DONE.
  - Done pulse is high in cycle c0+N+2.
- WRITE:
  - Byte k is driven with ram_wr = 1, ram_dout = wdata[8k+7:8k], in cycle c0+1+k.
  - Go to DONE; pulse in cycle c0+N+1.
- IO stall: a write with addr[17:16] == IO_ADDR_HI while io_buffer_full = 1 holds the current byte with ram_wr = 0 and retries each cycle until io_buffer_full = 0.
- DONE:
  - Assert exactly one of lsb_done / if_done for one cycle; data output valid in the same cycle.
  - Return to IDLE.
  - No new request is accepted in DONE, because the requester drops its signal on that edge.
- Short loads: unused upper bytes of lsb_rdata = 0. Sign extension is done by the LSB.
- clear_signal (with rdy_in = 1):
  - An in-flight fetch or load (READ) is aborted: next state IDLE, no done pulse, ram_a = 0.
  - A store in WRITE always completes and pulses lsb_done.
  - A clear in IDLE blocks acceptance that cycle.
  - A clear in DONE does not cancel the pulse.
- rdy_in = 0:
  - All state and counters are frozen; ram_wr is driven 0.
  - On resume in READ, the address of the oldest uncaptured byte is reissued first (adds one cycle); bytes already captured are kept.
- Address arithmetic is 32-bit wrap; no alignment check is performed.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00; if_signal, if_addr = 0x100 at c0 -> ram_a 0x100..0x103 in c1..c4; if_done = 1 in c6 with if_data = 0x00100513.
- LSB word load at 0x200 (bytes EF,BE,AD,DE) together with if_signal in the same cycle -> LSB served first; lsb_rdata = 0xDEADBEEF at c6; fetch starts at c7.
- Store half: lsb_wr = 1, lsb_len = 01, addr 0x40, wdata 0x1234ABCD -> ram_wr = 1 with ram_a/ram_dout 0x40/CD in c1 and 0x41/AB in c2; lsb_done in c3; RAM[0x41:0x40] = ABCD.
- Byte load of 0x80 at 0x10 -> lsb_rdata = 0x00000080 at c3.
- IO store of 1 byte to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 for 3 cycles, then one write cycle, then lsb_done.
- clear_signal in c2 of a word load -> no lsb_done, state IDLE at c3. clear_signal in c2 of a word store -> all 4 bytes written, lsb_done at c5.
